// File: rtl/morse_pkg.sv
// Shared constants, pattern table and FSM state for the Morse output path.
// Letter codes are 3 bits; each maps to a 15-bit pattern sent MSB first.
package morse_pkg;

  localparam int CODE_W = 3;
  localparam int PAT_W  = 15;

  localparam logic [PAT_W-1:0] PATTERNS [8] = '{
    15'b010101000000000,
    15'b011100000000000,
    15'b010101110000000,
    15'b010101011100000,
    15'b010111011100000,
    15'b011101010111000,
    15'b011101011101110,
    15'b011101110100000
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  function automatic logic [PAT_W-1:0] pattern(
    input logic [CODE_W-1:0] code
  );
    return PATTERNS[code];
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Symbol tick generator: down-counter that fires once every TICK_DIV run cycles.
// restart reloads the counter so a new letter starts on a full symbol period.
module morse_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == '0);

  // count down while running, reload on wrap or restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (run) begin
      cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Message-level Morse controller: letter queue, pattern shifter, gap timer.
// morse_out drives the LED/buzzer directly, one pattern bit per symbol tick.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_TICKS = 3,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [CODE_W-1:0]          in_code,
  output logic                       in_ready,
  output logic                       morse_out,
  output logic                       busy,
  output logic                       letter_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(PAT_W);
  localparam int GW = $clog2(GAP_TICKS + 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_t            state;
  logic [PAT_W-1:0]  shreg;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic push;
  logic pop;
  logic run;
  logic restart;
  logic tick;

  assign in_ready = fifo_count < CW'(DEPTH);
  assign push     = in_valid && in_ready && !clear;
  assign pop      = (state == IDLE) && enable
                 && (fifo_count != '0) && !clear;
  assign run      = enable && (state != IDLE);
  assign restart  = clear || pop;

  morse_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .restart(restart),
    .tick   (tick)
  );

  // queue storage, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // queue pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // letter FSM with registered outputs; enable=0 freezes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      morse_out   <= 1'b0;
      busy        <= 1'b0;
      letter_done <= 1'b0;
    end else begin
      letter_done <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        shreg     <= '0;
        bit_cnt   <= '0;
        gap_cnt   <= '0;
        morse_out <= 1'b0;
        busy      <= 1'b0;
      end else if (enable) begin
        unique case (state)
          IDLE: begin
            morse_out <= 1'b0;
            if (pop) begin
              shreg   <= pattern(mem[rd_ptr]);
              bit_cnt <= '0;
              state   <= SHIFT;
              busy    <= 1'b1;
            end
          end
          SHIFT: begin
            morse_out <= shreg[PAT_W-1];
            if (tick) begin
              shreg   <= {shreg[PAT_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                letter_done <= 1'b1;
                if (GAP_TICKS > 0) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          GAP: begin
            morse_out <= 1'b0;
            if (tick) begin
              if (gap_cnt == GAP_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: directed scenarios plus random traffic,
// checked every cycle against a per-letter timeline model.
module tb_morse_sequencer;

  localparam int TD    = 4;
  localparam int GAPT  = 3;
  localparam int DEPTH = 4;
  localparam int PW    = 15;
  localparam int LET   = PW * TD;
  localparam int LAST  = LET + GAPT * TD;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic       morse_out;
  logic       busy;
  logic       letter_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  morse_sequencer #(
    .TICK_DIV (TD),
    .GAP_TICKS(GAPT),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .morse_out  (morse_out),
    .busy       (busy),
    .letter_done(letter_done),
    .fifo_count (fifo_count)
  );

  logic [14:0] pats [8] = '{
    15'b010101000000000, 15'b011100000000000,
    15'b010101110000000, 15'b010101011100000,
    15'b010111011100000, 15'b011101010111000,
    15'b011101011101110, 15'b011101110100000
  };

  // model: p = enabled cycles since the letter was popped (0 = idle)
  int          q[$];
  int          p;
  logic        adv;
  logic [14:0] cur;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    logic eo;
    int   idx;
    eo = 1'b0;
    if (p >= 2 && p <= LET + 1) begin
      idx = PW - 1 - (p - 2) / TD;
      eo  = cur[idx];
    end
    check("morse_out", 32'(morse_out), 32'(eo));
    check("busy", 32'(busy), 32'(p != 0));
    check("letter_done", 32'(letter_done),
          32'((p == LET + 1) && adv));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic step(input bit v, input bit [2:0] c,
                      input bit en, input bit clr);
    bit do_push;
    in_valid = v;
    in_code  = c;
    enable   = en;
    clear    = clr;
    if (clr) begin
      q.delete();
      p   = 0;
      adv = 1'b0;
    end else begin
      do_push = v && (q.size() < DEPTH);
      adv     = 1'b0;
      if (p == 0) begin
        if (en && q.size() > 0) begin
          cur = pats[q.pop_front()];
          p   = 1;
          adv = 1'b1;
        end
      end else if (en) begin
        p++;
        adv = 1'b1;
        if (p > LAST) p = 0;
      end
      if (do_push) q.push_back(int'(c));
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_morse_out", 32'(morse_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    p   = 0;
    adv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    compare_all();
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_code  = 3'd0;
    p        = 0;
    adv      = 1'b0;
    cur      = '0;
    repeat (3) @(negedge clk);
    compare_all();
    reset = 1'b1;
    idle(2);

    // single letter code 1
    step(1'b1, 3'd1, 1'b1, 1'b0);
    idle(80);

    // back-to-back 0, 7, 3
    step(1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b0);
    step(1'b1, 3'd3, 1'b1, 1'b0);
    idle(3 * (LAST + 1) + 10);

    // fill while paused; fifth push dropped
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'(i + 2), 1'b0, 1'b0);
    idle(4 * (LAST + 1) + 10);

    // pause mid-SHIFT on code 6
    step(1'b1, 3'd6, 1'b1, 1'b0);
    idle(30);
    for (int i = 0; i < 10; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
    idle(80);

    // clear mid-letter with two queued
    step(1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    idle(20);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    idle(5);

    // async reset mid-letter, then code 2
    step(1'b1, 3'd3, 1'b1, 1'b0);
    idle(20);
    async_reset();
    step(1'b1, 3'd2, 1'b1, 1'b0);
    idle(80);

    // random traffic in segments of varying density
    for (int s = 0; s < 12; s++) begin
      int pv;
      int pe;
      pv = $urandom_range(5, 60);
      pe = $urandom_range(60, 100);
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 99) < pv,
             3'($urandom_range(0, 7)),
             $urandom_range(0, 99) < pe,
             $urandom_range(0, 999) < 3);
      end
      if (s == 6) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
